// File: rtl/register_file_pkg.sv
// Shared constants and types for the architectural register file and its read ports.
package register_file_pkg;

  typedef logic [31:0] DATA_TYPE;
  typedef logic [4:0]  REG_POS_TYPE;
  typedef logic [4:0]  ROB_ID_TYPE;

  localparam DATA_TYPE    ZERO_WORD = 32'h0;
  localparam ROB_ID_TYPE  ZERO_ROB  = 5'd0;
  localparam REG_POS_TYPE ZERO_REG  = 5'd0;
  localparam logic        TRUE      = 1'b1;
  localparam logic        FALSE     = 1'b0;

endpackage

// File: rtl/register_file_reg_read_port.sv
// One combinational read port: index -> (tag, value), x0 forced to zero.
// Optional same-cycle commit forwarding when REG_FILE_COMMIT_BYPASS_EN is defined.
module reg_read_port
  import register_file_pkg::*;
#(
  parameter int REG_NUM = 32
) (
  input  REG_POS_TYPE rs_i,
  input  ROB_ID_TYPE  tag_i   [REG_NUM],
  input  DATA_TYPE    value_i [REG_NUM],
  input  logic        commit_flag_i,
  input  REG_POS_TYPE commit_rd_i,
  input  ROB_ID_TYPE  commit_q_i,
  input  DATA_TYPE    commit_v_i,
  output ROB_ID_TYPE  q_o,
  output DATA_TYPE    v_o
);

`ifdef REG_FILE_COMMIT_BYPASS_EN
  logic bypass_hit;
  // Forward only when the committing ROB entry is still the register's producer.
  assign bypass_hit = commit_flag_i && (commit_rd_i == rs_i) && (tag_i[rs_i] == commit_q_i);
`else
  logic bypass_hit;
  logic unused_bypass_inputs;
  assign bypass_hit           = FALSE;
  assign unused_bypass_inputs = ^{commit_flag_i, commit_rd_i, commit_q_i, commit_v_i};
`endif

  always_comb begin
    q_o = tag_i[rs_i];
    v_o = value_i[rs_i];
    if (rs_i == ZERO_REG) begin
      q_o = ZERO_ROB;
      v_o = ZERO_WORD;
    end else if (bypass_hit) begin
`ifdef REG_FILE_COMMIT_BYPASS_EN
      q_o = ZERO_ROB;
      v_o = commit_v_i;
`endif
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags (0 = value valid).
// Build option REG_FILE_COMMIT_BYPASS_EN forwards a matching commit to reads in the same cycle.
module register_file
  import register_file_pkg::*;
#(
  parameter int REG_NUM  = 32,
  parameter int ROB_ID_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  REG_POS_TYPE rs1_from_dispatcher,
  input  REG_POS_TYPE rs2_from_dispatcher,
  output ROB_ID_TYPE  Q1_to_dispatcher,
  output ROB_ID_TYPE  Q2_to_dispatcher,
  output DATA_TYPE    V1_to_dispatcher,
  output DATA_TYPE    V2_to_dispatcher,
  input  logic        rename_flag_from_dispatcher,
  input  REG_POS_TYPE rd_from_dispatcher,
  input  ROB_ID_TYPE  rob_id_from_dispatcher,
  input  logic        commit_flag_from_rob,
  input  REG_POS_TYPE rd_from_rob,
  input  ROB_ID_TYPE  Q_from_rob,
  input  DATA_TYPE    V_from_rob,
  input  logic        misbranch_flag_from_rob
);

  logic [ROB_ID_W-1:0] tag_q   [REG_NUM];
  logic [ROB_ID_W-1:0] tag_d   [REG_NUM];
  DATA_TYPE            value_q [REG_NUM];
  DATA_TYPE            value_d [REG_NUM];

  // Commit writes the value always; the tag clear loses to a flush or a same-cycle rename.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    if (commit_flag_from_rob && rd_from_rob != ZERO_REG) begin
      value_d[rd_from_rob] = V_from_rob;
      if (tag_q[rd_from_rob] == Q_from_rob) tag_d[rd_from_rob] = ZERO_ROB;
    end
    if (misbranch_flag_from_rob) begin
      for (int i = 0; i < REG_NUM; i++) tag_d[i] = ZERO_ROB;
    end else if (rename_flag_from_dispatcher && rd_from_dispatcher != ZERO_REG) begin
      tag_d[rd_from_dispatcher] = rob_id_from_dispatcher;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        tag_q[i]   <= ZERO_ROB;
        value_q[i] <= ZERO_WORD;
      end
    end else if (rdy) begin
      tag_q   <= tag_d;
      value_q <= value_d;
    end
  end

  reg_read_port #(.REG_NUM(REG_NUM)) u_read_rs1 (
    .rs_i          (rs1_from_dispatcher),
    .tag_i         (tag_q),
    .value_i       (value_q),
    .commit_flag_i (commit_flag_from_rob),
    .commit_rd_i   (rd_from_rob),
    .commit_q_i    (Q_from_rob),
    .commit_v_i    (V_from_rob),
    .q_o           (Q1_to_dispatcher),
    .v_o           (V1_to_dispatcher)
  );

  reg_read_port #(.REG_NUM(REG_NUM)) u_read_rs2 (
    .rs_i          (rs2_from_dispatcher),
    .tag_i         (tag_q),
    .value_i       (value_q),
    .commit_flag_i (commit_flag_from_rob),
    .commit_rd_i   (rd_from_rob),
    .commit_q_i    (Q_from_rob),
    .commit_v_i    (V_from_rob),
    .q_o           (Q2_to_dispatcher),
    .v_o           (V2_to_dispatcher)
  );

endmodule

// File: doc/register_file.md
# register_file

Architectural register file with rename tags; it consumes the reorder buffer's commit port and the misbranch flush. It holds 32 × 32-bit values plus one ROB tag per register (0 = value valid). The dispatcher uses it for two things: to look up source operands (tag or value), and to rename the destination register to a freshly allocated ROB id. It sits between the dispatcher and the reorder buffer's commit outputs.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers
- ROB_ID_W, 5, ROB id width (0 = no producer; 1..16 valid)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- rdy  input  1  global ready; low = hold all state
- rs1_from_dispatcher  input  5  source register 1 index
- rs2_from_dispatcher  input  5  source register 2 index
- Q1_to_dispatcher  output  5  producer tag of rs1 (0 = V1 valid)
- Q2_to_dispatcher  output  5  producer tag of rs2
- V1_to_dispatcher  output  32  value of rs1 (meaningful when Q1 = 0)
- V2_to_dispatcher  output  32  value of rs2
- rename_flag_from_dispatcher  input  1  rename destination this cycle
- rd_from_dispatcher  input  5  destination register to rename
- rob_id_from_dispatcher  input  5  ROB id allocated to rd
- commit_flag_from_rob  input  1  commit valid
- rd_from_rob  input  5  committed destination
- Q_from_rob  input  5  committing ROB id
- V_from_rob  input  32  committed value
- misbranch_flag_from_rob  input  1  flush all rename tags

## Operation
- State: value[0..31], tag[0..31]. x0 is hardwired: reads return Q=0, V=0; writes and renames to x0 are ignored.
- Commit (commit_flag && rd_from_rob != 0):
  - value[rd] <= V_from_rob.
  - If tag[rd] == Q_from_rob, then tag[rd] <= 0.
  - A tag mismatch means a younger rename exists; the tag is kept and the value is still written.
- Rename (rename_flag && rd_from_dispatcher != 0 && !misbranch): tag[rd] <= rob_id_from_dispatcher.
- Misbranch: every tag <= 0. A commit in the same cycle still writes its value. Any rename in that cycle is dropped.
- Priority on the same rd in one cycle: rename tag beats the commit tag-clear; the value write still happens.
- Reads are combinational from current state. They return the pre-rename state: a dispatcher reading rs == rd in its own rename cycle sees the old tag.
- Storage reads, when tag[rs] != 0: Q = tag[rs], V = value[rs] (stale).
- No stall outputs; the block always accepts rename and commit.

## Timing
- Reset: all value and tag entries become 0. Q1/Q2/V1/V2 therefore read 0 from the first cycle after reset.
- rst has priority over rdy. rst mid-operation discards all tags and values within one cycle.
- rdy low: no state update; reads still reflect the held state.
- Commit and rename take effect at the next posedge; latency 1 cycle to visibility without bypass.
- Bypass latency: 0 cycles when enabled (see Configuration).

## Configuration
- REG_FILE_COMMIT_BYPASS_EN, when defined:
  - A read of rs with tag[rs] == Q_from_rob, commit_flag high and rd_from_rob == rs returns Q = 0, V = V_from_rob in the same cycle.
  - Bypass still applies in a misbranch cycle.
- Undefined: reads return stored state only, and the committed value is visible the following cycle.

## Structure
- The shared constants include holds DATA_TYPE, REG_POS_TYPE, ROB_ID_TYPE, ZERO_ROB, ZERO_WORD, ZERO_REG, TRUE/FALSE. No new typedefs are local to this block.
- One sub-module, reg_read_port: it does index → (Q, V), with the x0 check and the optional bypass. It is instantiated twice, for rs1 and rs2.

## Test plan
- Reset, then read rs1=5, rs2=0 → Q1=0, V1=0, Q2=0, V2=0.
- Rename x5→ROB 3, then commit rd=5, Q=3, V=0x1234 → next cycle Q=0, V=0x1234.
- Rename x5→3, rename x5→7, commit rd=5, Q=3, V=0xAA → tag stays 7, value=0xAA.
- Same cycle: commit rd=6, Q=2, V=0x55 and rename x6→4 → tag[6]=4, value[6]=0x55.
- Tags on x1..x4 = 1..4, then misbranch with commit rd=1, V=9 and rename x8→5 → all tags 0, x1=9, tag[8]=0.
- With bypass, tag[9]=4 and commit rd=9, Q=4, V=0xBEEF while reading rs1=9 → same cycle Q1=0, V1=0xBEEF. Without bypass → Q1=4 that cycle, Q1=0 next cycle.
